// File: rtl/dcr_pkg.sv
// Shared defaults, window-size helper and FSM state type for the DC offset remover.
package dcr_pkg;
  localparam int DCR_DATA_WIDTH = 12;
  localparam int DCR_AVG_WINDOW = 1024;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } dcr_state_e;

  // Exact log2 of a power-of-two window length.
  function automatic int log2_win(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) == n) r = i;
    return r;
  endfunction
endpackage

// File: rtl/adc_edge_sync.sv
// Brings the ADC clock into the clk domain and flags each rising edge with a one-cycle strobe.
module adc_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic adc_clk,
  output logic strobe
);
  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= adc_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign strobe = s2 & ~s3;
endmodule

// File: rtl/dc_offset_remover.sv
// Block-average DC offset removal for an unsigned ADC stream.
// Define DCR_SATURATE_EN to clamp the difference instead of wrapping it.
module dc_offset_remover
  import dcr_pkg::*;
#(
  parameter int DATA_WIDTH = DCR_DATA_WIDTH,
  parameter int AVG_WINDOW = DCR_AVG_WINDOW
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         adc_clk,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         clr,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         out_vld,
  output logic                         en
);
  localparam int LOG2_WIN = log2_win(AVG_WINDOW);
  localparam int ACC_W    = DATA_WIDTH + LOG2_WIN;

  dcr_state_e            state, state_nxt;
  logic                  strobe, cap, win_close;
  logic [ACC_W-1:0]      acc, sum;
  logic [LOG2_WIN-1:0]   cnt;
  logic [DATA_WIDTH-1:0] mean, red, red_q;
  logic                  vld_q, run_q;

  adc_edge_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .adc_clk(adc_clk),
    .strobe (strobe)
  );

  assign cap       = strobe & ~clr;
  assign win_close = cap & (&cnt);
  assign sum       = acc + {{LOG2_WIN{1'b0}}, data_in};

`ifdef DCR_SATURATE_EN
  localparam logic signed [DATA_WIDTH:0] SAT_MAX = {2'b00, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH:0] SAT_MIN = {2'b11, {(DATA_WIDTH-1){1'b0}}};
  logic signed [DATA_WIDTH:0] diff;

  always_comb begin
    diff = $signed({1'b0, data_in}) - $signed({1'b0, mean});
    red  = diff[DATA_WIDTH-1:0];
    if (diff > SAT_MAX)      red = SAT_MAX[DATA_WIDTH-1:0];
    else if (diff < SAT_MIN) red = SAT_MIN[DATA_WIDTH-1:0];
  end
`else
  // Low bits of the (DATA_WIDTH+1)-bit difference are identical to a DATA_WIDTH-bit subtract.
  always_comb begin
    red = data_in - mean;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr)            state_nxt = FILL;
    else if (win_close) state_nxt = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      mean     <= '0;
      red_q    <= '0;
      run_q    <= 1'b0;
      vld_q    <= 1'b0;
      data_out <= '0;
      out_vld  <= 1'b0;
      en       <= 1'b0;
    end else if (clr) begin
      acc      <= '0;
      cnt      <= '0;
      mean     <= '0;
      red_q    <= '0;
      run_q    <= 1'b0;
      vld_q    <= 1'b0;
      data_out <= '0;
      out_vld  <= 1'b0;
      en       <= 1'b0;
    end else begin
      vld_q   <= cap;
      out_vld <= vld_q;
      if (cap) begin
        // Difference uses the mean in force before this sample, even on window close.
        red_q <= red;
        run_q <= (state == RUN);
        if (win_close) begin
          mean <= sum[ACC_W-1:LOG2_WIN];
          acc  <= '0;
          cnt  <= '0;
        end else begin
          acc  <= sum;
          cnt  <= cnt + 1'b1;
        end
      end
      if (vld_q) begin
        data_out <= run_q ? red_q : '0;
        en       <= run_q;
      end
    end
  end
endmodule

// File: tb/tb_dc_offset_remover.sv
// Scoreboard bench for dc_offset_remover: fill, sine offset, reset, reduction mode and clr.
module tb_dc_offset_remover;
  localparam int DW  = 12;
  localparam int WIN = 1024;

  logic                 clk = 1'b0, rst_n = 1'b0, adc_clk = 1'b0, clr = 1'b0;
  logic [DW-1:0]        data_in = '0;
  logic signed [DW-1:0] data_out;
  logic                 out_vld, en;

  int checks = 0, errors = 0, cyc = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          en;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  int m_acc, m_cnt, m_mean;
  bit m_run;

  dc_offset_remover #(.DATA_WIDTH(DW), .AVG_WINDOW(WIN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .adc_clk (adc_clk),
    .data_in (data_in),
    .clr     (clr),
    .data_out(data_out),
    .out_vld (out_vld),
    .en      (en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] model_reduce(input int v);
    int t;
    t = v;
`ifdef DCR_SATURATE_EN
    if (t > 2047)  t = 2047;
    if (t < -2048) t = -2048;
`endif
    return t[DW-1:0];
  endfunction

  task automatic model_clear();
    m_acc = 0; m_cnt = 0; m_mean = 0; m_run = 0;
  endtask

  // One ADC period of 5 clk: rises at N0, falls at N3, returns at N4 after the output edge.
  task automatic sample(input int d, input bit clr_cap = 1'b0);
    exp_t e;
    @(negedge clk);
    data_in = d[DW-1:0];
    adc_clk = 1'b1;
    if (!clr_cap) begin
      e.data = m_run ? model_reduce(d - m_mean) : '0;
      e.en   = m_run;
      e.cyc  = cyc + 4;  // first sampling edge is cyc+1; output lands 3 edges later
      sb.push_back(e);
      m_acc += d;
      if (m_cnt == WIN - 1) begin
        m_mean = m_acc >> 10;
        m_acc  = 0;
        m_cnt  = 0;
        m_run  = 1'b1;
      end else m_cnt++;
    end else model_clear();
    @(negedge clk);
    @(negedge clk);
    if (clr_cap) clr = 1'b1;
    @(negedge clk);
    clr     = 1'b0;
    adc_clk = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    model_clear();
  endtask

  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (rst_n && out_vld) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_vld cyc=%0d data_out=%0d", cyc, data_out);
      end else begin
        e = sb.pop_front();
        if (data_out !== e.data || en !== e.en || cyc != e.cyc) begin
          errors++;
          $display("FAIL scoreboard got data=%h en=%b cyc=%0d want data=%h en=%b cyc=%0d",
                   data_out, en, cyc, e.data, e.en, e.cyc);
        end
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (data_out !== '0 || out_vld !== 1'b0 || en !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got data=%h vld=%b en=%b want 0 0 0", data_out, out_vld, en);
    end
    rst_n = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    checks++;
    if (data_out !== '0 || out_vld !== 1'b0 || en !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got data=%h vld=%b en=%b want 0 0 0", data_out, out_vld, en);
    end
  endtask

  task automatic test_const_fill();
    int bad = 0;
    for (int i = 0; i < WIN; i++) begin
      sample(2048);
      if (en !== 1'b0 || data_out !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL fill_const bad=%0d want 0", bad); end
    sample(2048);
    checks++;
    if (en !== 1'b1 || data_out !== '0) begin
      errors++;
      $display("FAIL fill_first_run got en=%b data=%0d want en=1 data=0", en, data_out);
    end
  endtask

  task automatic test_sine();
    int bad = 0, s;
    real r, dv;
    pulse_clr();
    for (int i = 0; i < 3 * WIN; i++) begin
      r = 1024.0 * $sin(2.0 * 3.14159265358979 * i / 256.0);
      s = $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
      sample(3071 + s);
      if (i >= WIN) begin
        dv = $itor(data_out) - r;
        if (dv > 2.0 || dv < -2.0 || en !== 1'b1) bad++;
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL sine_tolerance bad=%0d want 0", bad); end
  endtask

  task automatic test_reset_mid_run();
    int bad = 0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (data_out !== '0 || out_vld !== 1'b0 || en !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got data=%h vld=%b en=%b want 0 0 0", data_out, out_vld, en);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < WIN; i++) begin
      sample(1000);
      if (en !== 1'b0 || data_out !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_refill bad=%0d want 0", bad); end
    sample(1000);
    checks++;
    if (en !== 1'b1 || data_out !== '0) begin
      errors++;
      $display("FAIL reset_recover got en=%b data=%0d want en=1 data=0", en, data_out);
    end
  endtask

  task automatic test_reduce();
    logic [DW-1:0] want;
`ifdef DCR_SATURATE_EN
    want = 12'h7FF;
`else
    want = 12'hFFF;
`endif
    pulse_clr();
    for (int i = 0; i < WIN; i++) sample(0);
    sample(4095);
    checks++;
    if (data_out !== want || en !== 1'b1) begin
      errors++;
      $display("FAIL reduce got data=%h en=%b want data=%h en=1", data_out, en, want);
    end
  endtask

  task automatic test_clr();
    int bad = 0;
    pulse_clr();
    for (int i = 0; i < WIN; i++) sample(500);
    for (int i = 0; i < 500; i++) sample(700);
    checks++;
    if (en !== 1'b1 || data_out !== 12'sd200) begin
      errors++;
      $display("FAIL clr_pre got en=%b data=%0d want en=1 data=200", en, data_out);
    end
    pulse_clr();
    checks++;
    if (en !== 1'b0 || data_out !== '0 || out_vld !== 1'b0) begin
      errors++;
      $display("FAIL clr_drop got en=%b data=%0d vld=%b want 0 0 0", en, data_out, out_vld);
    end
    for (int i = 0; i < WIN; i++) begin
      sample(300);
      if (en !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL clr_refill bad=%0d want 0", bad); end
    sample(300);
    checks++;
    if (en !== 1'b1 || data_out !== '0) begin
      errors++;
      $display("FAIL clr_recover got en=%b data=%0d want en=1 data=0", en, data_out);
    end
    sample(300, 1'b1);
    checks++;
    if (out_vld !== 1'b0 || en !== 1'b0) begin
      errors++;
      $display("FAIL clr_with_strobe got vld=%b en=%b want 0 0", out_vld, en);
    end
    sample(300);
    sample(300);
  endtask

  initial begin
    model_clear();
    test_reset();
    test_const_fill();
    test_sine();
    test_reset_mid_run();
    test_reduce();
    test_clr();
    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_outputs got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
